// File: rtl/ccsds_turbo_enc_asm_insert_if.sv
// Serial stream bundle between the puncture stage and the ASM insertion stage:
// punctured codeword bits in, channel bits (ASM followed by codeword) out.
interface ccsds_turbo_enc_asm_insert_if;
    logic [1:0] icode;
    logic       isop;
    logic       ival;
    logic       ieop;
    logic       idat;
    logic       osop;
    logic       oval;
    logic       oeop;
    logic       odat;
    logic       oerr;

    modport master (
        output icode, isop, ival, ieop, idat,
        input  osop, oval, oeop, odat, oerr
    );

    modport slave (
        input  icode, isop, ival, ieop, idat,
        output osop, oval, oeop, odat, oerr
    );
endinterface

// File: rtl/ccsds_turbo_enc_asm_insert.sv
// Prepends the rate-dependent attached sync marker to each punctured codeword,
// holding codeword bits in a circular bit buffer while the marker is sent.
module ccsds_turbo_enc_asm_insert #(
    parameter int pBUF_AW = 8
) (
    input  logic                              iclk,
    input  logic                              iresetn,
    input  logic                              iclkena,
    ccsds_turbo_enc_asm_insert_if.slave       bus
);

    localparam logic [1:0] cCODE_1by2 = 2'd0;
    localparam logic [1:0] cCODE_1by3 = 2'd1;
    localparam logic [1:0] cCODE_1by4 = 2'd2;
    localparam logic [1:0] cCODE_1by6 = 2'd3;

    typedef enum logic [1:0] {IDLE, ASM, DATA, TAIL} state_t;

    function automatic logic [191:0] asmWord(input logic [1:0] code);
        case (code)
            cCODE_1by2: asmWord = {128'd0, 64'h034776C7272895B0};
            cCODE_1by3: asmWord = {96'd0, 96'h25D5C0CE8990F6C9461BF79C};
            cCODE_1by4: asmWord = {64'd0, 128'h034776C7272895B0FCB88938D8D76A4F};
            default:    asmWord = 192'h25D5C0CE8990F6C9461BF79CDA2A3F31766F0936B9E40863;
        endcase
    endfunction

    function automatic logic [7:0] asmLen(input logic [1:0] code);
        case (code)
            cCODE_1by2: asmLen = 8'd64;
            cCODE_1by3: asmLen = 8'd96;
            cCODE_1by4: asmLen = 8'd128;
            cCODE_1by6: asmLen = 8'd192;
            default:    asmLen = 8'd192;
        endcase
    endfunction

    state_t               state_q, state_d;
    logic [7:0]           asmCnt_q, asmCnt_d;
    logic [1:0]           code_q, code_d;
    logic [pBUF_AW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic                 drop_q, drop_d;
    logic                 inFrame_q, inFrame_d;
    logic                 osop_q, osop_d, oval_q, oval_d, oeop_q, oeop_d;
    logic                 odat_q, odat_d, oerr_q, oerr_d;
    logic                 wrEn;
    logic [1:0]           rdEntry;
    logic [191:0]         newAsm, curAsm;
    logic [7:0]           newLen;
    logic [1:0]           mem_q [2**pBUF_AW];

    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            state_q   <= IDLE;
            asmCnt_q  <= '0;
            code_q    <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            drop_q    <= 1'b0;
            inFrame_q <= 1'b0;
            osop_q    <= 1'b0;
            oval_q    <= 1'b0;
            oeop_q    <= 1'b0;
            odat_q    <= 1'b0;
            oerr_q    <= 1'b0;
        end else if (iclkena) begin
            state_q   <= state_d;
            asmCnt_q  <= asmCnt_d;
            code_q    <= code_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            drop_q    <= drop_d;
            inFrame_q <= inFrame_d;
            osop_q    <= osop_d;
            oval_q    <= oval_d;
            oeop_q    <= oeop_d;
            odat_q    <= odat_d;
            oerr_q    <= oerr_d;
        end
    end

    // Buffer entries carry the eop tag alongside the bit so the reader knows where the frame ends.
    always_ff @(posedge iclk) begin
        if (iclkena && wrEn) begin
            mem_q[wp_q] <= {bus.ieop, bus.idat};
        end
    end

    always_comb begin
        state_d   = state_q;
        asmCnt_d  = asmCnt_q;
        code_d    = code_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        drop_d    = drop_q;
        inFrame_d = inFrame_q;
        osop_d    = 1'b0;
        oval_d    = 1'b0;
        oeop_d    = 1'b0;
        odat_d    = 1'b0;
        oerr_d    = 1'b0;
        wrEn      = 1'b0;
        newAsm    = asmWord(bus.icode);
        newLen    = asmLen(bus.icode);
        curAsm    = asmWord(code_q);
        rdEntry   = mem_q[rp_q];

        // A rejected sop discards everything up to its own eop; the running frame is untouched.
        if (bus.ival) begin
            if (bus.isop && state_q == IDLE) begin
                wrEn      = 1'b1;
                drop_d    = 1'b0;
                inFrame_d = !bus.ieop;
                code_d    = bus.icode;
            end else if (bus.isop) begin
                oerr_d = 1'b1;
                drop_d = !bus.ieop;
            end else if (drop_q) begin
                if (bus.ieop) drop_d = 1'b0;
            end else if (inFrame_q) begin
                wrEn = 1'b1;
                if (bus.ieop) inFrame_d = 1'b0;
            end
        end
        if (wrEn) wp_d = wp_q + 1'b1;

        // The first marker bit is registered on the accept edge, so the counter starts at L-2.
        case (state_q)
            IDLE: begin
                if (bus.ival && bus.isop) begin
                    osop_d   = 1'b1;
                    oval_d   = 1'b1;
                    odat_d   = newAsm[newLen - 8'd1];
                    asmCnt_d = newLen - 8'd2;
                    state_d  = ASM;
                end
            end
            ASM: begin
                oval_d   = 1'b1;
                odat_d   = curAsm[asmCnt_q];
                asmCnt_d = asmCnt_q - 8'd1;
                if (asmCnt_q == 8'd0) state_d = DATA;
            end
            DATA: begin
                if (wp_q != rp_q) begin
                    oval_d = 1'b1;
                    odat_d = rdEntry[0];
                    oeop_d = rdEntry[1];
                    rp_d   = rp_q + 1'b1;
                    if (rdEntry[1]) state_d = TAIL;
                end
            end
            TAIL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.osop = osop_q;
    assign bus.oval = oval_q;
    assign bus.oeop = oeop_q;
    assign bus.odat = odat_q;
    assign bus.oerr = oerr_q;

endmodule

// File: tb/tb_ccsds_turbo_enc_asm_insert.sv
// Scoreboard bench for the ASM insertion stage: the driver pushes the expected
// channel bit stream per accepted frame, a negedge monitor pops and compares.
module tb_ccsds_turbo_enc_asm_insert;

    logic iclk    = 1'b0;
    logic iresetn = 1'b0;
    logic iclkena = 1'b1;

    ccsds_turbo_enc_asm_insert_if dutIf();

    ccsds_turbo_enc_asm_insert #(.pBUF_AW(8)) dut (
        .iclk    (iclk),
        .iresetn (iresetn),
        .iclkena (iclkena),
        .bus     (dutIf)
    );

    always #5 iclk = ~iclk;

    typedef struct packed {
        logic isAsm;
        logic sop;
        logic eop;
        logic dat;
    } outBit_t;

    outBit_t    expQ[$];
    int         sopCycQ[$];
    int         eopCycQ[$];
    int         errQ[$];
    int         cyc    = 0;
    logic       lastEn = 1'b1;
    int         nChecks = 0;
    int         nPass   = 0;
    logic [4:0] prevOut = '0;
    logic [4:0] curOut;
    outBit_t    monBit;
    int         monCyc;

    // Reference marker table, MSB first.
    function automatic logic [191:0] refAsmWord(input logic [1:0] code);
        case (code)
            2'd0:    return {128'd0, 64'h034776C7272895B0};
            2'd1:    return {96'd0, 96'h25D5C0CE8990F6C9461BF79C};
            2'd2:    return {64'd0, 128'h034776C7272895B0FCB88938D8D76A4F};
            default: return 192'h25D5C0CE8990F6C9461BF79CDA2A3F31766F0936B9E40863;
        endcase
    endfunction

    function automatic int refAsmLen(input logic [1:0] code);
        case (code)
            2'd0:    return 64;
            2'd1:    return 96;
            2'd2:    return 128;
            default: return 192;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    always @(posedge iclk) begin
        cyc++;
        lastEn = iclkena;
    end

    // Monitor: consume one expected bit per valid output cycle.
    always @(negedge iclk) begin
        if (iresetn) begin
            curOut = {dutIf.osop, dutIf.oval, dutIf.oeop, dutIf.odat, dutIf.oerr};
            if (!lastEn) begin
                checkOutput("freeze_hold", 32'(curOut), 32'(prevOut));
            end else begin
                if (dutIf.oerr) begin
                    if (errQ.size() == 0) checkOutput("unexpected_oerr", 1, 0);
                    else begin
                        monCyc = errQ.pop_front();
                        checkOutput("oerr_cycle", cyc, monCyc + 1);
                    end
                end
                if (dutIf.oval) begin
                    if (expQ.size() == 0) checkOutput("unexpected_oval", 1, 0);
                    else begin
                        monBit = expQ.pop_front();
                        checkOutput("bit_sop_eop_dat", {29'd0, dutIf.osop, dutIf.oeop, dutIf.odat},
                                    {29'd0, monBit.sop, monBit.eop, monBit.dat});
                        if (monBit.isAsm && !monBit.sop) checkOutput("asm_contiguous", 32'(prevOut[3]), 1);
                        if (monBit.sop && sopCycQ.size() > 0) begin
                            monCyc = sopCycQ.pop_front();
                            checkOutput("osop_latency", cyc, monCyc + 1);
                        end
                        if (monBit.eop && eopCycQ.size() > 0) begin
                            monCyc = eopCycQ.pop_front();
                            if (monCyc >= 0) checkOutput("oeop_cycle", cyc, monCyc);
                        end
                    end
                end else if (dutIf.osop || dutIf.oeop) begin
                    checkOutput("marker_without_oval", {30'd0, dutIf.osop, dutIf.oeop}, 0);
                end
            end
            prevOut = curOut;
        end
    end

    task automatic driveIdle();
        @(posedge iclk); #1;
        dutIf.ival = 1'b0;
        dutIf.isop = 1'b0;
        dutIf.ieop = 1'b0;
        dutIf.idat = 1'b0;
    endtask

    // Drives bit 0 in the current cycle; gapMode 0 = gap-free, 1 = alternate, 2 = random gaps.
    task automatic applyStimulus(input logic [1:0] code, input int len, input logic [255:0] bits,
                                 input int gapMode, input bit timed, input bit accept);
        logic [191:0] refW;
        int           refL;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                if (gapMode == 1) driveIdle();
                else if (gapMode == 2) while ($urandom_range(99) < 30) driveIdle();
                @(posedge iclk); #1;
            end
            dutIf.icode = code;
            dutIf.ival  = 1'b1;
            dutIf.isop  = (i == 0);
            dutIf.ieop  = (i == len - 1);
            dutIf.idat  = bits[i];
            if (i == 0) begin
                if (accept) begin
                    refW = refAsmWord(code);
                    refL = refAsmLen(code);
                    for (int j = refL - 1; j >= 0; j--)
                        expQ.push_back('{isAsm: 1'b1, sop: (j == refL - 1), eop: 1'b0, dat: refW[j]});
                    for (int j = 0; j < len; j++)
                        expQ.push_back('{isAsm: 1'b0, sop: 1'b0, eop: (j == len - 1), dat: bits[j]});
                    sopCycQ.push_back(cyc);
                    eopCycQ.push_back(timed ? cyc + refL + len : -1);
                end else begin
                    errQ.push_back(cyc);
                end
            end
        end
        driveIdle();
    endtask

    task automatic waitIdle();
        int k;
        for (k = 0; k < 3000; k++) begin
            if (expQ.size() == 0) break;
            driveIdle();
        end
        if (k == 3000) checkOutput("drain_timeout", expQ.size(), 0);
        repeat (3) driveIdle();
    endtask

    logic [255:0] bits;
    logic [15:0]  word16;
    int           len;
    int           k;
    logic [1:0]   rc;
    int           gm;

    initial begin
        dutIf.icode = 2'd0;
        dutIf.ival  = 1'b0;
        dutIf.isop  = 1'b0;
        dutIf.ieop  = 1'b0;
        dutIf.idat  = 1'b0;
        repeat (3) @(posedge iclk);
        #1;
        checkOutput("reset_osop", 32'(dutIf.osop), 0);
        checkOutput("reset_oval", 32'(dutIf.oval), 0);
        checkOutput("reset_oeop", 32'(dutIf.oeop), 0);
        checkOutput("reset_odat", 32'(dutIf.odat), 0);
        checkOutput("reset_oerr", 32'(dutIf.oerr), 0);
        iresetn = 1'b1;
        repeat (2) driveIdle();

        // Stray valid bits without sop are discarded.
        @(posedge iclk); #1;
        dutIf.ival = 1'b1; dutIf.idat = 1'b1;
        driveIdle();

        $display("[TB] rate 1/2, 16'hA5C3 gap-free");
        word16 = 16'hA5C3;
        bits = '0;
        for (int i = 0; i < 16; i++) bits[i] = word16[15 - i];
        applyStimulus(2'd0, 16, bits, 0, 1'b1, 1'b1);
        waitIdle();

        $display("[TB] rate 1/6, 8'hFF with alternating valid");
        bits = '0;
        for (int i = 0; i < 8; i++) bits[i] = 1'b1;
        applyStimulus(2'd3, 8, bits, 1, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] rate 1/3 with rejected second sop");
        bits = '0; bits[0] = 1'b1; bits[1] = 1'b0;
        applyStimulus(2'd1, 2, bits, 0, 1'b1, 1'b1);
        bits = '0; bits[0] = 1'b1; bits[1] = 1'b1; bits[2] = 1'b1;
        applyStimulus(2'd0, 3, bits, 0, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] rate 1/4 back-to-back");
        bits = '0;
        for (int i = 0; i < 8; i++) bits[i] = 1'($urandom_range(1));
        applyStimulus(2'd2, 8, bits, 0, 1'b1, 1'b1);
        for (k = 0; k < 2000; k++) begin
            if (dutIf.oeop) break;
            @(posedge iclk); #1;
        end
        checkOutput("oeop_wait_timeout", (k == 2000) ? 32'd1 : 32'd0, 0);
        bits = '0; bits[0] = 1'b1;
        applyStimulus(2'd2, 1, bits, 0, 1'b0, 1'b0);
        bits = '0;
        for (int i = 0; i < 5; i++) bits[i] = 1'($urandom_range(1));
        applyStimulus(2'd2, 5, bits, 0, 1'b1, 1'b1);
        waitIdle();

        $display("[TB] reset during rate 1/3 ASM");
        bits = '0;
        for (int i = 0; i < 10; i++) bits[i] = 1'($urandom_range(1));
        applyStimulus(2'd1, 10, bits, 0, 1'b1, 1'b1);
        repeat (10) driveIdle();
        #2 iresetn = 1'b0;
        #1;
        checkOutput("midreset_osop", 32'(dutIf.osop), 0);
        checkOutput("midreset_oval", 32'(dutIf.oval), 0);
        checkOutput("midreset_oeop", 32'(dutIf.oeop), 0);
        checkOutput("midreset_odat", 32'(dutIf.odat), 0);
        checkOutput("midreset_oerr", 32'(dutIf.oerr), 0);
        expQ.delete();
        sopCycQ.delete();
        eopCycQ.delete();
        repeat (2) driveIdle();
        iresetn = 1'b1;
        driveIdle();
        bits = '0; bits[0] = 1'b1;
        applyStimulus(2'd1, 1, bits, 0, 1'b1, 1'b1);
        waitIdle();

        $display("[TB] clock enable freeze mid-DATA");
        bits = '0;
        for (int i = 0; i < 16; i++) bits[i] = 1'($urandom_range(1));
        applyStimulus(2'd0, 16, bits, 0, 1'b0, 1'b1);
        repeat (55) driveIdle();
        iclkena = 1'b0;
        dutIf.ival = 1'b1; dutIf.isop = 1'b1; dutIf.ieop = 1'b1; dutIf.idat = 1'b1;
        repeat (5) begin @(posedge iclk); #1; end
        iclkena = 1'b1;
        dutIf.ival = 1'b0; dutIf.isop = 1'b0; dutIf.ieop = 1'b0; dutIf.idat = 1'b0;
        waitIdle();

        $display("[TB] randomized frames");
        for (int f = 0; f < 4; f++) begin
            rc  = 2'($urandom_range(3));
            len = $urandom_range(1, 40);
            gm  = ($urandom_range(1) == 1) ? 2 : 0;
            bits = '0;
            for (int i = 0; i < len; i++) bits[i] = 1'($urandom_range(1));
            applyStimulus(rc, len, bits, gm, (gm == 0), 1'b1);
            waitIdle();
        end

        checkOutput("leftover_expected_bits", expQ.size(), 0);
        checkOutput("missing_oerr", errQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d expected bits pending", expQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
